// File: rtl/rv_iommu_wsi_irq_arbiter.sv
// Edge-detects the IOMMU wired-signaled interrupt vector, latches pending events and
// serialises them round-robin onto a valid/ready interrupt-message channel.
module rv_iommu_wsi_irq_arbiter #(
  parameter int unsigned N_INT_VEC = 16,
  parameter int unsigned ID_W      = (N_INT_VEC > 1) ? $clog2(N_INT_VEC) : 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_INT_VEC-1:0] wsi_wires_i,
  input  logic [N_INT_VEC-1:0] mask_i,
  output logic                 irq_valid_o,
  output logic [ID_W-1:0]      irq_id_o,
  input  logic                 irq_ready_i,
  output logic [N_INT_VEC-1:0] pending_o,
  output logic [CNT_W-1:0]     coalesce_cnt_o,
  input  logic                 cnt_clr_i
);

  localparam int unsigned SumW = CNT_W + 5;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  state_e                 state_q, state_d;
  logic [N_INT_VEC-1:0]   prev_q;
  logic [N_INT_VEC-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [N_INT_VEC-1:0]   rise;
  logic [N_INT_VEC-1:0]   hs_vec;
  logic [N_INT_VEC-1:0]   coalesce;
  logic [N_INT_VEC-1:0]   elig;
  logic [N_INT_VEC-1:0]   elig_post;
  logic [SumW-1:0]        coal_sum;
  logic [SumW-1:0]        cnt_sum;
  logic                   hs;
  pick_t                  pick;

  // First set bit of vec at or after ptr, wrapping modulo N_INT_VEC.
  function automatic pick_t rr_pick(input logic [N_INT_VEC-1:0] vec,
                                    input logic [ID_W-1:0]      ptr);
    pick_t                res;
    logic [N_INT_VEC-1:0] shifted;
    int unsigned          j;
    res = '0;
    for (int unsigned k = 0; k < N_INT_VEC; k++) begin
      j       = (32'(ptr) + k) % N_INT_VEC;
      shifted = vec >> j;
      if (!res.found && shifted[0]) begin
        res.found = 1'b1;
        res.idx   = ID_W'(j);
      end
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (32'(id) >= N_INT_VEC - 1) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

  assign irq_valid_o    = (state_q == StOffer);
  assign irq_id_o       = id_q;
  assign pending_o      = pending_q;
  assign coalesce_cnt_o = cnt_q;

  assign rise      = wsi_wires_i & ~prev_q;
  assign hs        = irq_valid_o & irq_ready_i;
  assign hs_vec    = hs ? (N_INT_VEC'(1) << id_q) : '0;
  // A rise on the vector being accepted re-arms it rather than coalescing.
  assign pending_d = rise | (pending_q & ~hs_vec);
  assign coalesce  = rise & pending_q & ~hs_vec;
  assign elig      = pending_q & ~mask_i;
  assign elig_post = pending_q & ~hs_vec & ~mask_i;

  always_comb begin
    coal_sum = '0;
    for (int unsigned k = 0; k < N_INT_VEC; k++) begin
      coal_sum = coal_sum + SumW'(coalesce[k]);
    end
    cnt_sum = SumW'(cnt_q) + coal_sum;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_sum > SumW'(CntMax)) begin
      cnt_d = CntMax;
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    pick     = '0;
    unique case (state_q)
      StIdle: begin
        pick = rr_pick(elig, rr_ptr_q);
        if (pick.found) begin
          state_d = StOffer;
          id_d    = pick.idx;
        end
      end
      StOffer: begin
        if (irq_ready_i) begin
          rr_ptr_d = next_ptr(id_q);
          pick     = rr_pick(elig_post, rr_ptr_d);
          if (pick.found) begin
            id_d = pick.idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= wsi_wires_i;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_iommu_wsi_irq_arbiter.sv
// Directed bench for rv_iommu_wsi_irq_arbiter: cycle table plus hand-written
// saturation and reset-during-offer sequences.
module tb_rv_iommu_wsi_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wires;
  logic [15:0] mask;
  logic        ready;
  logic        clr;
  logic        valid;
  logic [3:0]  id;
  logic [15:0] pend;
  logic [15:0] cnt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] w;
    logic [15:0] m;
    logic        r;
    logic        c;
    logic        ev;
    logic [3:0]  eid;
    logic [15:0] ep;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  rv_iommu_wsi_irq_arbiter #(
    .N_INT_VEC(16),
    .ID_W     (4),
    .CNT_W    (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wsi_wires_i   (wires),
    .mask_i        (mask),
    .irq_valid_o   (valid),
    .irq_id_o      (id),
    .irq_ready_i   (ready),
    .pending_o     (pend),
    .coalesce_cnt_o(cnt),
    .cnt_clr_i     (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] w, input logic [15:0] m, input logic r,
                     input logic c, input logic ev, input logic [3:0] eid,
                     input logic [15:0] ep, input logic [15:0] ec);
    vec_t v;
    v.w = w; v.m = m; v.r = r; v.c = c;
    v.ev = ev; v.eid = eid; v.ep = ep; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    rst   = 1'b1;
    wires = '0;
    mask  = '0;
    ready = 1'b0;
    clr   = 1'b0;

    // Round-robin from pointer 0: 1, 4, 9 back-to-back
    add(16'h0212, 16'h0, 1, 0, 0, 0,  16'h0212, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 1,  16'h0212, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 4,  16'h0210, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 9,  16'h0200, 0);
    add(16'h0000, 16'h0, 1, 0, 0, 0,  16'h0000, 0);
    // Pointer now 10: 11 wins over 0, then wrap to 0
    add(16'h0801, 16'h0, 1, 0, 0, 0,  16'h0801, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 11, 16'h0801, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 0,  16'h0001, 0);
    add(16'h0000, 16'h0, 1, 0, 0, 0,  16'h0000, 0);
    // Single pulse on wire 3: pending, offer, done
    add(16'h0008, 16'h0, 1, 0, 0, 0,  16'h0008, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 3,  16'h0008, 0);
    add(16'h0000, 16'h0, 1, 0, 0, 0,  16'h0000, 0);
    // Vector 2 stalled by ready low while vector 0 arrives
    add(16'h0004, 16'h0, 0, 0, 0, 0,  16'h0004, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 2,  16'h0004, 0);
    add(16'h0001, 16'h0, 0, 0, 1, 2,  16'h0005, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 2,  16'h0005, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 2,  16'h0005, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 2,  16'h0005, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 2,  16'h0005, 0);
    add(16'h0000, 16'h0, 1, 0, 1, 0,  16'h0001, 0);
    add(16'h0000, 16'h0, 1, 0, 0, 0,  16'h0000, 0);
    // Coalescing on offered vector 6, then clear beats a same-cycle increment
    add(16'h0040, 16'h0, 0, 0, 0, 0,  16'h0040, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 6,  16'h0040, 0);
    add(16'h0040, 16'h0, 0, 0, 1, 6,  16'h0040, 1);
    add(16'h0000, 16'h0, 0, 0, 1, 6,  16'h0040, 1);
    add(16'h0040, 16'h0, 0, 0, 1, 6,  16'h0040, 2);
    add(16'h0000, 16'h0, 0, 0, 1, 6,  16'h0040, 2);
    add(16'h0040, 16'h0, 0, 0, 1, 6,  16'h0040, 3);
    add(16'h0000, 16'h0, 0, 0, 1, 6,  16'h0040, 3);
    add(16'h0040, 16'h0, 0, 1, 1, 6,  16'h0040, 0);
    add(16'h0000, 16'h0, 1, 0, 0, 0,  16'h0000, 0);
    // Rise on the vector being accepted re-arms it, no coalesce
    add(16'h0010, 16'h0, 0, 0, 0, 0,  16'h0010, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 4,  16'h0010, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 4,  16'h0010, 0);
    add(16'h0010, 16'h0, 1, 0, 0, 0,  16'h0010, 0);
    add(16'h0000, 16'h0, 0, 0, 1, 4,  16'h0010, 0);
    add(16'h0000, 16'h0, 1, 0, 0, 0,  16'h0000, 0);
    // Masked vector 5 latches but is not offered until unmasked
    add(16'h0020, 16'h0020, 1, 0, 0, 0, 16'h0020, 0);
    add(16'h0020, 16'h0020, 1, 0, 0, 0, 16'h0020, 0);
    add(16'h0020, 16'h0020, 1, 0, 0, 0, 16'h0020, 0);
    add(16'h0020, 16'h0000, 0, 0, 1, 5, 16'h0020, 0);
    add(16'h0020, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    add(16'h0020, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(valid), 0);
    chk("reset id",    32'(id),    0);
    chk("reset pend",  32'(pend),  0);
    chk("reset cnt",   32'(cnt),   0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      wires = tbl[i].w;
      mask  = tbl[i].m;
      ready = tbl[i].r;
      clr   = tbl[i].c;
      step();
      chk($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d id", i), 32'(id), 32'(tbl[i].eid));
      chk($sformatf("row%0d pend", i), 32'(pend), 32'(tbl[i].ep));
      chk($sformatf("row%0d cnt", i),  32'(cnt),  32'(tbl[i].ec));
    end

    // Saturation: all 16 masked vectors toggled; each pair after the first adds 16
    clr   = 1'b0;
    ready = 1'b0;
    mask  = 16'hFFFF;
    wires = 16'h0000;
    step();
    for (int p = 1; p <= 4200; p++) begin
      wires = 16'hFFFF;
      step();
      wires = 16'h0000;
      step();
      if (p == 3) chk("sat partial cnt", 32'(cnt), 32);
    end
    chk("sat cnt",   32'(cnt),   32'hFFFF);
    chk("sat pend",  32'(pend),  32'hFFFF);
    chk("sat valid", 32'(valid), 0);

    // Offer vector 5 only, then reset while offering
    mask = 16'hFFDF;
    step();
    chk("offer5 valid", 32'(valid), 1);
    chk("offer5 id",    32'(id),    5);
    wires = 16'h0020;
    step();
    chk("sat hold cnt", 32'(cnt), 32'hFFFF);
    chk("offer5 hold",  32'(id),  5);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(valid), 0);
    chk("async rst id",    32'(id),    0);
    chk("async rst pend",  32'(pend),  0);
    chk("async rst cnt",   32'(cnt),   0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    mask  = 16'h0000;
    ready = 1'b1;
    step();
    chk("post rst pend",  32'(pend),  32'h0020);
    chk("post rst valid", 32'(valid), 0);
    step();
    chk("post rst offer", 32'(valid), 1);
    chk("post rst id",    32'(id),    5);
    step();
    chk("post rst done",  32'(valid), 0);
    chk("post rst clear", 32'(pend),  0);
    step();
    chk("held level quiet", 32'(pend),  0);
    chk("held level idle",  32'(valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
